fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0): bubble encoding.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port stall  input  1  decode not accepting; hold the presented instruction and the fetch PC.
REQ-006 SHALL have port pc_sel  input  1  taken redirect (branch/jump resolved in EX).
REQ-007 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-008 SHALL have port imem_addr  output  32  byte address to synchronous imem (data returns next cycle).
REQ-009 SHALL have port imem_rdata  input  32  imem read data for the address presented the previous cycle.
REQ-010 SHALL have port inst  output  32  instruction presented to decode.
REQ-011 SHALL have port inst_pc  output  32  byte address of inst.
REQ-012 SHALL have port inst_valid  output  1  inst is a real (non-squashed) instruction.
REQ-013 SHALL have port fetch_count  output  32  count of instructions handed to decode.

Function
REQ-014 SHALL hold fetch PC register pc_f; imem_addr = pc_f combinationally.
REQ-015 Edge priority for pc_f SHALL be: pc_sel -> redirect_pc; else stall -> hold; else pc_f+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-016 pc_sel SHALL take priority over stall in every register update.
REQ-017 SHALL register pc_q <= pc_f on every non-stalled edge; pc_q is the address whose data is on imem_rdata.
REQ-018 SHALL keep squash_q, set on any edge with pc_sel=1, cleared otherwise unless stall=1, which holds it.
REQ-019 SHALL keep hold_inst/hold_pc/hold_v; on edge with stall=1, pc_sel=0, hold_v=0: capture current inst, inst_pc, inst_valid, set hold_v.
REQ-020 hold_v SHALL clear on any edge with stall=0 or pc_sel=1.
REQ-021 Output select: pc_sel=1 -> inst=NOP_INST, inst_valid=0 (combinational squash of wrong-path instruction entering EX).
REQ-022 Else hold_v=1 -> inst=hold_inst, inst_pc=hold_pc, inst_valid=held valid.
REQ-023 Else squash_q=1 -> inst=NOP_INST, inst_valid=0, inst_pc=pc_q.
REQ-024 Else inst=imem_rdata, inst_pc=pc_q, inst_valid=1.
REQ-025 Redirect latency: target instruction SHALL appear with inst_valid=1 exactly 2 cycles after the pc_sel edge when stall=0.
REQ-026 Back-to-back pc_sel on consecutive cycles SHALL each redirect; the last target wins, no valid instruction between.
REQ-027 fetch_count SHALL increment by 1 (wrapping) on each edge with inst_valid=1, stall=0, pc_sel=0.
REQ-028 Stall held for N cycles SHALL present identical inst/inst_pc/inst_valid for all N+1 cycles and lose no instruction.

Reset
REQ-029 On rst=1, without waiting for clk: pc_f=RESET_PC, pc_q=RESET_PC, squash_q=1, hold_v=0, hold_inst=NOP_INST, hold_pc=0, fetch_count=0.
REQ-030 During and first cycle after reset release, SHALL output inst=NOP_INST, inst_valid=0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; first valid instruction is from RESET_PC, 2 cycles after release.

Verification
REQ-032 Reset release, stall=0, imem returns addr as data -> cycle 1 valid=0; cycle 2 inst=32'h4000_0000, inst_pc=32'h4000_0000; then +4 per cycle; fetch_count increments each cycle.
REQ-033 Stall 3 cycles while inst_pc=32'h4000_0008 -> inst/inst_pc frozen 4 cycles; next cycle inst_pc=32'h4000_000C; no skip/duplicate; fetch_count +1 total over stall window.
REQ-034 pc_sel=1, redirect_pc=32'h4000_0100 at inst_pc=32'h4000_0010 -> same cycle valid=0; next cycle valid=0; following cycle inst_pc=32'h4000_0100, valid=1.
REQ-035 pc_sel and stall both 1 -> redirect taken, hold cleared, target valid 2 cycles later.
REQ-036 pc_sel on two consecutive cycles (targets 0x200, 0x300) -> only 0x300 stream emerges, valid after 2 cycles from the second.
REQ-037 rst pulsed asynchronously mid-stall -> outputs immediately NOP/valid=0, fetch_count=0; restart from RESET_PC per REQ-032.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, synchronous-imem fetch, redirect squash and stall hold for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic [31:0] fetch_count
);
    logic [31:0] pcf_q, pcf_d, pc_q, pc_d, hold_inst_q, hold_inst_d, hold_pc_q, hold_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        squash_q, squash_d, hold_v_q, hold_v_d, hold_valid_q, hold_valid_d;
    logic        capture;

    always_comb begin
        imem_addr     = pcf_q;
        fetch_count   = fetch_count_q;
        inst          = pc_sel ? NOP_INST : hold_v_q ? hold_inst_q : squash_q ? NOP_INST : imem_rdata;
        inst_pc       = hold_v_q ? hold_pc_q : pc_q;
        inst_valid    = pc_sel ? 1'b0 : hold_v_q ? hold_valid_q : !squash_q;
        pcf_d         = pc_sel ? redirect_pc : stall ? pcf_q : pcf_q + 32'd4;
        pc_d          = (pc_sel || !stall) ? pcf_q : pc_q;
        squash_d      = pc_sel ? 1'b1 : stall ? squash_q : 1'b0;
        // First stalled edge freezes whatever decode currently sees
        capture       = stall && !pc_sel && !hold_v_q;
        hold_v_d      = stall && !pc_sel;
        hold_inst_d   = capture ? inst : hold_inst_q;
        hold_pc_d     = capture ? inst_pc : hold_pc_q;
        hold_valid_d  = capture ? inst_valid : hold_valid_q;
        fetch_count_d = (inst_valid && !stall && !pc_sel) ? fetch_count_q + 32'd1 : fetch_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf_q         <= RESET_PC;
            pc_q          <= RESET_PC;
            squash_q      <= 1'b1;
            hold_v_q      <= 1'b0;
            hold_inst_q   <= NOP_INST;
            hold_pc_q     <= 32'd0;
            hold_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pcf_q         <= pcf_d;
            pc_q          <= pc_d;
            squash_q      <= squash_d;
            hold_v_q      <= hold_v_d;
            hold_inst_q   <= hold_inst_d;
            hold_pc_q     <= hold_pc_d;
            hold_valid_q  <= hold_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against an imem that returns its address as data.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, pc_sel = 1'b0;
    logic [31:0] redirect_pc = 32'd0, imem_addr, imem_rdata, inst, inst_pc, fetch_count;
    logic inst_valid;
    int errors = 0, checks = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) imem_rdata <= imem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_inst(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
        #1;
        check({tag, " inst"}, inst, pc);
        check({tag, " pc"}, inst_pc, pc);
        check({tag, " valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, " count"}, fetch_count, cnt);
    endtask

    task automatic expect_bubble(input string tag);
        #1;
        check({tag, " inst"}, inst, NOP);
        check({tag, " valid"}, {31'd0, inst_valid}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        expect_bubble("in_reset");
        check("in_reset count", fetch_count, 32'd0);
        check("in_reset addr", imem_addr, 32'h4000_0000);
        rst = 1'b0;
        expect_bubble("post_rel");
        cyc();
        for (int i = 0; i < 3; i++) begin
            expect_inst("stream", 32'h4000_0000 + 32'(4 * i), 32'(i));
            if (i < 2) cyc();
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_inst("stalled", 32'h4000_0008, 32'd2);
            cyc();
        end
        stall = 1'b0;
        expect_inst("stall_last", 32'h4000_0008, 32'd2);
        cyc();
        expect_inst("after_stall", 32'h4000_000C, 32'd3);
        cyc();
        expect_inst("pre_redir", 32'h4000_0010, 32'd4);
        pc_sel = 1'b1;
        redirect_pc = 32'h4000_0100;
        expect_bubble("redir_same");
        cyc();
        pc_sel = 1'b0;
        expect_bubble("redir_next");
        cyc();
        expect_inst("redir_tgt", 32'h4000_0100, 32'd4);
        cyc();
        expect_inst("redir_tgt4", 32'h4000_0104, 32'd5);
        stall = 1'b1;
        cyc();
        expect_inst("hold_pre", 32'h4000_0104, 32'd5);
        pc_sel = 1'b1;
        redirect_pc = 32'h4000_0180;
        expect_bubble("sel_stall");
        cyc();
        pc_sel = 1'b0;
        stall = 1'b0;
        expect_bubble("sel_stall_next");
        cyc();
        expect_inst("sel_stall_tgt", 32'h4000_0180, 32'd5);
        cyc();
        expect_inst("sel_stall_tgt4", 32'h4000_0184, 32'd6);
        pc_sel = 1'b1;
        redirect_pc = 32'h4000_0200;
        expect_bubble("b2b_first");
        cyc();
        redirect_pc = 32'h4000_0300;
        expect_bubble("b2b_second");
        cyc();
        pc_sel = 1'b0;
        expect_bubble("b2b_gap");
        cyc();
        expect_inst("b2b_tgt", 32'h4000_0300, 32'd6);
        cyc();
        expect_inst("b2b_tgt4", 32'h4000_0304, 32'd7);
        stall = 1'b1;
        cyc();
        cyc();
        #2 rst = 1'b1;
        expect_bubble("async_rst");
        check("async_rst count", fetch_count, 32'd0);
        check("async_rst addr", imem_addr, 32'h4000_0000);
        check("async_rst pc", inst_pc, 32'h4000_0000);
        stall = 1'b0;
        cyc();
        rst = 1'b0;
        expect_bubble("rerel");
        cyc();
        expect_inst("restart0", 32'h4000_0000, 32'd0);
        cyc();
        expect_inst("restart1", 32'h4000_0004, 32'd1);
        pc_sel = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        expect_bubble("wrap_sel");
        cyc();
        pc_sel = 1'b0;
        cyc();
        expect_inst("wrap_f8", 32'hFFFF_FFF8, 32'd1);
        cyc();
        expect_inst("wrap_fc", 32'hFFFF_FFFC, 32'd2);
        cyc();
        expect_inst("wrap_0", 32'h0000_0000, 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
